video_crop_window: RTL and testbench

- AXI4-Stream video crop stage. It sits directly downstream of the RGB normalizer, taking the 256x256 24-bit stream and feeding the OLED converter.
- It forwards only the pixels inside a rectangular window, for example 96x64 for the OLED.
- It regenerates tuser (start of frame) and tlast (end of line) for the cropped stream.
- Window parameters are sampled at each start of frame, so a frame is never torn.

---
 rtl/video_crop_window.sv | 127 ++++++++++++
 tb/tb_video_crop_window.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_crop_window.sv
// AXI4-Stream crop stage: forwards only pixels inside a rectangular window and regenerates
// tuser (start of frame) / tlast (end of line) for the cropped stream.
module video_crop_window #(
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDATA_WIDTH = 24,
  parameter int unsigned X_WIDTH     = 10,
  parameter int unsigned Y_WIDTH     = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   param_enable,
  input  logic [X_WIDTH-1:0]     param_x_start,
  input  logic [X_WIDTH-1:0]     param_x_end,
  input  logic [Y_WIDTH-1:0]     param_y_start,
  input  logic [Y_WIDTH-1:0]     param_y_end,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready
);

  typedef enum logic [0:0] {StWaitSof, StActive} state_e;

  state_e                 state_q;
  logic [X_WIDTH-1:0]     x_q, x_start_q, x_end_q;
  logic [Y_WIDTH-1:0]     y_q, y_start_q, y_end_q;
  logic                   enable_q;
  logic [TUSER_WIDTH-1:0] m_tuser_q;
  logic                   m_tlast_q;
  logic [TDATA_WIDTH-1:0] m_tdata_q;
  logic                   m_tvalid_q;

  logic                   accept, sof, process, keep;
  logic                   en_c;
  logic [X_WIDTH-1:0]     cur_x, xs_c, xe_c;
  logic [Y_WIDTH-1:0]     cur_y, ys_c, ye_c;
  logic [TUSER_WIDTH-1:0] tuser_c;
  logic                   tlast_c;

  assign s_axi4s_tready = !m_tvalid_q || m_axi4s_tready;
  assign accept         = s_axi4s_tvalid && s_axi4s_tready;
  assign sof            = s_axi4s_tuser[0];

  // An SOF beat is evaluated against the freshly sampled window as pixel (0,0).
  always_comb begin
    if (sof) begin
      en_c  = param_enable;
      xs_c  = param_x_start;
      xe_c  = param_x_end;
      ys_c  = param_y_start;
      ye_c  = param_y_end;
      cur_x = '0;
      cur_y = '0;
    end else begin
      en_c  = enable_q;
      xs_c  = x_start_q;
      xe_c  = x_end_q;
      ys_c  = y_start_q;
      ye_c  = y_end_q;
      cur_x = x_q;
      cur_y = y_q;
    end
    process = accept && (sof || (state_q == StActive));
    keep    = !en_c || ((cur_x >= xs_c) && (cur_x <= xe_c) &&
                        (cur_y >= ys_c) && (cur_y <= ye_c));
    tuser_c = s_axi4s_tuser;
    tlast_c = s_axi4s_tlast;
    if (en_c) begin
      tuser_c[0] = (cur_x == xs_c) && (cur_y == ys_c);
      tlast_c    = (cur_x == xe_c) || s_axi4s_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StWaitSof;
      x_q        <= '0;
      y_q        <= '0;
      x_start_q  <= '0;
      x_end_q    <= '0;
      y_start_q  <= '0;
      y_end_q    <= '0;
      enable_q   <= 1'b0;
      m_tuser_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      if (process) begin
        state_q   <= StActive;
        enable_q  <= en_c;
        x_start_q <= xs_c;
        x_end_q   <= xe_c;
        y_start_q <= ys_c;
        y_end_q   <= ye_c;
        // Counters saturate at all-ones rather than wrapping.
        if (s_axi4s_tlast) begin
          x_q <= '0;
          y_q <= (cur_y == '1) ? cur_y : cur_y + 1'b1;
        end else begin
          x_q <= (cur_x == '1) ? cur_x : cur_x + 1'b1;
          y_q <= cur_y;
        end
      end
      if (process && keep) begin
        m_tvalid_q <= 1'b1;
        m_tuser_q  <= tuser_c;
        m_tlast_q  <= tlast_c;
        m_tdata_q  <= s_axi4s_tdata;
      end else if (m_axi4s_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axi4s_tuser  = m_tuser_q;
  assign m_axi4s_tlast  = m_tlast_q;
  assign m_axi4s_tdata  = m_tdata_q;
  assign m_axi4s_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_video_crop_window.sv
// Randomized bench for video_crop_window: a frame-level reference model predicts every output
// beat from the crop rules; counts per frame are also checked against window arithmetic.
module tb_video_crop_window;

  localparam int TW = 1;
  localparam int DW = 24;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int FW = 40;
  localparam int FH = 30;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          param_enable = 1'b0;
  logic [XW-1:0] param_x_start = '0;
  logic [XW-1:0] param_x_end = '0;
  logic [YW-1:0] param_y_start = '0;
  logic [YW-1:0] param_y_end = '0;
  logic [TW-1:0] s_tuser = '0;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [TW-1:0] m_tuser;
  logic          m_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;

  always #5 clk = ~clk;

  video_crop_window #(
    .TUSER_WIDTH(TW),
    .TDATA_WIDTH(DW),
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .param_enable  (param_enable),
    .param_x_start (param_x_start),
    .param_x_end   (param_x_end),
    .param_y_start (param_y_start),
    .param_y_end   (param_y_end),
    .s_axi4s_tuser (s_tuser),
    .s_axi4s_tlast (s_tlast),
    .s_axi4s_tdata (s_tdata),
    .s_axi4s_tvalid(s_tvalid),
    .s_axi4s_tready(s_tready),
    .m_axi4s_tuser (m_tuser),
    .m_axi4s_tlast (m_tlast),
    .m_axi4s_tdata (m_tdata),
    .m_axi4s_tvalid(m_tvalid),
    .m_axi4s_tready(m_tready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int out_cnt = 0;
  bit rdy_rand = 1'b0;
  bit gap_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame state in plain ints, expected beats as {tuser, tlast, tdata}.
  logic [DW+1:0] exp_q[$];
  bit m_act = 1'b0;
  bit men = 1'b0;
  int mx, my, mxs, mxe, mys, mye;

  function automatic bit model_beat(input bit sof, input bit eol, input logic [DW-1:0] d);
    bit keep;
    bit u, l;
    if (sof) begin
      men = param_enable;
      mxs = int'(param_x_start);
      mxe = int'(param_x_end);
      mys = int'(param_y_start);
      mye = int'(param_y_end);
      m_act = 1'b1;
      mx = 0;
      my = 0;
    end
    if (!m_act) return 1'b0;
    keep = !men || (mx >= mxs && mx <= mxe && my >= mys && my <= mye);
    if (keep) begin
      u = men ? (mx == mxs && my == mys) : sof;
      l = men ? (mx == mxe || eol) : eol;
      exp_q.push_back({u, l, d});
    end
    if (eol) begin
      mx = 0;
      my++;
    end else begin
      mx++;
    end
    return keep;
  endfunction

  // Monitor on the falling edge, between driver updates.
  initial begin
    bit pushed_last = 1'b0;
    bit prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        m_act = 1'b0;
        pushed_last = 1'b0;
        prev_rdy = 1'b1;
        continue;
      end
      check_eq("s_tready", 64'(s_tready), 64'(!m_tvalid || m_tready));
      // With the consumer ready last cycle, every kept beat shows up exactly one cycle later.
      if (prev_rdy) check_eq("latency", 64'(m_tvalid), 64'(pushed_last));
      if (m_tvalid && m_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) check_eq("extra_beat", 64'(exp_q.size()), 64'd1);
        else check_eq("beat", 64'({m_tuser, m_tlast, m_tdata}), 64'(exp_q.pop_front()));
      end
      pushed_last = 1'b0;
      if (s_tvalid && s_tready) pushed_last = model_beat(s_tuser[0], s_tlast, s_tdata);
      prev_rdy = m_tready;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_beat(input bit sof, input bit eol, input logic [DW-1:0] d);
    int guard = 0;
    if (gap_rand) begin
      while ($urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_tuser  = TW'(sof);
    s_tlast  = eol;
    s_tdata  = d;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      guard++;
      if (guard > 1000) begin
        $display("FAIL send_beat: s_tready stuck low, got 0 expected 1");
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_params(input bit en, input int xs, input int xe, input int ys, input int ye);
    param_enable  = en;
    param_x_start = XW'(xs);
    param_x_end   = XW'(xe);
    param_y_start = YW'(ys);
    param_y_end   = YW'(ye);
  endtask

  task automatic run_frame(input string tag, input int short_row, input int short_len,
                           input int chg_row, input int chg_xe, input int rst_row,
                           input int exp_cnt);
    int c0 = out_cnt;
    for (int y = 0; y < FH; y++) begin
      int lw = (y == short_row) ? short_len : FW;
      if (y == chg_row) param_x_end = XW'(chg_xe);
      if (y == rst_row) begin
        drain();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_mvalid", 64'(m_tvalid), 64'd0);
      end
      for (int x = 0; x < lw; x++) send_beat(x == 0 && y == 0, x == lw - 1, DW'(y * 256 + x));
    end
    drain();
    if (exp_cnt >= 0) check_eq(tag, 64'(out_cnt - c0), 64'(exp_cnt));
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_eq("rst_tuser", 64'(m_tuser), 64'd0);
    check_eq("rst_tlast", 64'(m_tlast), 64'd0);
    check_eq("rst_tdata", 64'(m_tdata), 64'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_sready", 64'(s_tready), 64'd1);

    // Beats before any SOF are dropped.
    set_params(1'b0, 0, 0, 0, 0);
    c0 = out_cnt;
    for (int i = 0; i < 5; i++) send_beat(1'b0, i == 4, DW'(i));
    drain();
    check_eq("pre_sof_cnt", 64'(out_cnt - c0), 64'd0);

    set_params(1'b1, 8, 23, 5, 14);
    run_frame("crop_cnt", -1, 0, -1, 0, -1, 16 * 10);
    rdy_rand = 1'b1;
    gap_rand = 1'b1;
    run_frame("crop_bp_cnt", -1, 0, -1, 0, -1, 16 * 10);
    rdy_rand = 1'b0;
    gap_rand = 1'b0;
    drain();

    set_params(1'b0, 8, 23, 5, 14);
    run_frame("pass_cnt", -1, 0, -1, 0, -1, FW * FH);

    // x_end shrinks mid-frame: only the next frame sees it.
    set_params(1'b1, 8, 23, 5, 14);
    run_frame("chg_cur_cnt", -1, 0, 8, 11, -1, 16 * 10);
    run_frame("chg_next_cnt", -1, 0, -1, 0, -1, 4 * 10);

    set_params(1'b1, 8, 23, 5, 14);
    run_frame("short_cnt", 7, 13, -1, 0, -1, 9 * 16 + 5);
    set_params(1'b1, 30, 60, 0, FH - 1);
    run_frame("wide_cnt", -1, 0, -1, 0, -1, 10 * FH);
    set_params(1'b1, 20, 10, 0, FH - 1);
    run_frame("empty_x_cnt", -1, 0, -1, 0, -1, 0);
    set_params(1'b1, 0, FW - 1, 12, 3);
    run_frame("empty_y_cnt", -1, 0, -1, 0, -1, 0);
    set_params(1'b1, 0, 5, 0, 3);
    run_frame("sof_eol_cnt", 0, 1, -1, 0, -1, 1 + 3 * 6);

    set_params(1'b1, 8, 23, 5, 14);
    run_frame("rst_mid_cnt", -1, 0, -1, 0, 10, 5 * 16);
    run_frame("after_rst_cnt", -1, 0, -1, 0, -1, 16 * 10);

    rdy_rand = 1'b1;
    gap_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      set_params(1'($urandom_range(0, 3) != 0), $urandom_range(0, 45), $urandom_range(0, 45),
                 $urandom_range(0, 32), $urandom_range(0, 32));
      run_frame("rand_cnt", -1, 0, -1, 0, -1, -1);
    end
    rdy_rand = 1'b0;
    gap_rand = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
